line_feed_controller: RTL and testbench

Sequencer that sits between an upstream pixel source (DMA or stream FIFO) and `imageProcessTop`. It replays the line-buffer feed protocol in hardware: prime PRIME_LINES lines, then release one line per rising edge of `o_intr`, then append PAD_LINES zero lines. It also counts processed output pixels and reports frame completion, which removes the software or bench loop that currently drives the edge-detection datapath.

---
 rtl/line_feed_controller_if.sv | 23 ++
 rtl/line_feed_controller.sv | 183 ++++++++++++++++++
 tb/tb_line_feed_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/line_feed_controller_if.sv
// rtl/line_feed_controller_if.sv - pixel source and image processor handshake bundle
interface line_feed_controller_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] o_data;
   logic       o_data_valid;
   logic       i_proc_ready;
   logic       i_intr;
   logic       i_out_valid;

   // Controller view
   modport slave (
      input  s_data, s_valid, i_proc_ready, i_intr, i_out_valid,
      output s_ready, o_data, o_data_valid
   );

   // Source / processor environment view
   modport master (
      output s_data, s_valid, i_proc_ready, i_intr, i_out_valid,
      input  s_ready, o_data, o_data_valid
   );
endinterface

// File: rtl/line_feed_controller.sv
// rtl/line_feed_controller.sv - line-buffer feed sequencer; zero padding built when LFC_ZERO_PAD_EN is defined
module line_feed_controller #(
   parameter int LINE_LEN    = 256,
   parameter int PRIME_LINES = 4,
   parameter int IMG_PIXELS  = 51529,
   parameter int PAD_LINES   = 2,
   parameter int OUT_PIXELS  = 51529
) (
   input  logic                   axi_clk,
   input  logic                   axi_reset_n,
   input  logic                   i_start,
   line_feed_controller_if.slave  bus,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_credit_ovf
);
   localparam int BW          = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam int SW          = $clog2(IMG_PIXELS + 1);
   localparam int OW          = $clog2(OUT_PIXELS + 1);
   localparam int PRIME_BEATS = (PRIME_LINES * LINE_LEN < IMG_PIXELS) ? PRIME_LINES * LINE_LEN : IMG_PIXELS;
   localparam logic [BW-1:0] BEAT_LAST = BW'(LINE_LEN - 1);
   localparam logic [SW-1:0] IMG_END   = SW'(IMG_PIXELS);
   localparam logic [SW-1:0] PRIME_END = SW'(PRIME_BEATS);
   localparam logic [OW-1:0] OUT_END   = OW'(OUT_PIXELS);

   typedef enum logic [2:0] {
      ST_IDLE, ST_PRIME, ST_WAIT, ST_LINE, ST_PAD_WAIT, ST_PAD, ST_DRAIN
   } state_t;

`ifdef LFC_ZERO_PAD_EN
   localparam state_t ST_AFTER_IMG = ST_PAD_WAIT;
   localparam int PW = (PAD_LINES > 0) ? $clog2(PAD_LINES + 1) : 1;
   localparam logic [PW-1:0] PAD_END = PW'(PAD_LINES);
   logic [PW-1:0] pad_cnt;
`else
   localparam state_t ST_AFTER_IMG = ST_DRAIN;
   // PAD_LINES has no effect without the padding stage
   if (PAD_LINES < 0) begin : g_pad_lines_unused
   end
`endif

   state_t        state, state_nxt;
   logic [BW-1:0] beat_cnt;
   logic [SW-1:0] sent_cnt;
   logic [SW-1:0] sent_inc;
   logic [OW-1:0] out_cnt;
   logic [1:0]    credit;
   logic          intr_q, intr_q2, intr_edge;
   logic          start_acc, take_credit, xfer, line_done;

   assign sent_inc  = sent_cnt + SW'(1);
   assign intr_edge = intr_q & ~intr_q2 & (state != ST_IDLE);
   assign o_busy    = (state != ST_IDLE);

   // Next-state logic and the combinational data path for each state
   always_comb begin
      state_nxt        = state;
      start_acc        = 1'b0;
      take_credit      = 1'b0;
      xfer             = 1'b0;
      line_done        = 1'b0;
      bus.o_data       = '0;
      bus.o_data_valid = 1'b0;
      bus.s_ready      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_start) begin
               start_acc = 1'b1;
               state_nxt = ST_PRIME;
            end
         end
         ST_PRIME, ST_LINE: begin
            bus.o_data       = bus.s_data;
            bus.o_data_valid = bus.s_valid;
            bus.s_ready      = bus.i_proc_ready;
            xfer             = bus.s_valid & bus.i_proc_ready;
            line_done        = xfer && (beat_cnt == BEAT_LAST || sent_inc == IMG_END);
            if (xfer) begin
               if (state == ST_PRIME) begin
                  if (sent_inc == IMG_END)        state_nxt = ST_AFTER_IMG;
                  else if (sent_inc == PRIME_END) state_nxt = ST_WAIT;
               end else if (line_done) begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (credit != 2'd0) begin
               take_credit = 1'b1;
               state_nxt   = ST_LINE;
            end else if (sent_cnt == IMG_END) begin
               state_nxt = ST_AFTER_IMG;
            end
         end
`ifdef LFC_ZERO_PAD_EN
         ST_PAD_WAIT: begin
            if (pad_cnt == PAD_END) begin
               state_nxt = ST_DRAIN;
            end else if (credit != 2'd0) begin
               take_credit = 1'b1;
               state_nxt   = ST_PAD;
            end
         end
         ST_PAD: begin
            bus.o_data_valid = 1'b1;
            xfer             = bus.i_proc_ready;
            line_done        = xfer && (beat_cnt == BEAT_LAST);
            if (line_done) state_nxt = ST_PAD_WAIT;
         end
`endif
         ST_DRAIN: begin
            if (out_cnt == OUT_END) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register and interrupt synchroniser / edge history
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         state   <= ST_IDLE;
         intr_q  <= 1'b0;
         intr_q2 <= 1'b0;
      end else begin
         state   <= state_nxt;
         intr_q  <= bus.i_intr;
         intr_q2 <= intr_q;
      end
   end

   // Beat, sent and pad-line counters advance only on transferred beats
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         beat_cnt <= '0;
         sent_cnt <= '0;
`ifdef LFC_ZERO_PAD_EN
         pad_cnt  <= '0;
`endif
      end else if (start_acc) begin
         beat_cnt <= '0;
         sent_cnt <= '0;
`ifdef LFC_ZERO_PAD_EN
         pad_cnt  <= '0;
`endif
      end else if (xfer) begin
         beat_cnt <= line_done ? '0 : beat_cnt + BW'(1);
         if (state != ST_PAD) sent_cnt <= sent_inc;
`ifdef LFC_ZERO_PAD_EN
         if (state == ST_PAD && line_done) pad_cnt <= pad_cnt + PW'(1);
`endif
      end
   end

   // Line credit: saturating at 3, simultaneous grant and use cancel out
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         credit       <= 2'd0;
         o_credit_ovf <= 1'b0;
      end else if (start_acc) begin
         credit       <= 2'd0;
         o_credit_ovf <= 1'b0;
      end else if (intr_edge && !take_credit) begin
         if (credit == 2'd3) o_credit_ovf <= 1'b1;
         else                credit       <= credit + 2'd1;
      end else if (!intr_edge && take_credit) begin
         credit <= credit - 2'd1;
      end
   end

   // Processed-pixel counter and frame-done pulse (coincides with the return to idle)
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         out_cnt <= '0;
         o_done  <= 1'b0;
      end else begin
         o_done <= (state == ST_DRAIN) && (out_cnt == OUT_END);
         if (start_acc)
            out_cnt <= '0;
         else if (state != ST_IDLE && bus.i_out_valid && out_cnt != OUT_END)
            out_cnt <= out_cnt + OW'(1);
      end
   end
endmodule

// File: tb/tb_line_feed_controller.sv
// tb/tb_line_feed_controller.sv - directed bench for line_feed_controller
module tb_line_feed_controller;
   localparam int LINE_LEN    = 8;
   localparam int PRIME_LINES = 4;
   localparam int IMG_PIXELS  = 64;
   localparam int PAD_LINES   = 2;
   localparam int OUT_PIXELS  = 64;
`ifdef LFC_ZERO_PAD_EN
   localparam int EXP_PAD = PAD_LINES * LINE_LEN;
`else
   localparam int EXP_PAD = 0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic busy, done, ovf;

   line_feed_controller_if bus();

   line_feed_controller #(
      .LINE_LEN    (LINE_LEN),
      .PRIME_LINES (PRIME_LINES),
      .IMG_PIXELS  (IMG_PIXELS),
      .PAD_LINES   (PAD_LINES),
      .OUT_PIXELS  (OUT_PIXELS)
   ) dut (
      .axi_clk      (clk),
      .axi_reset_n  (rst_n),
      .i_start      (start),
      .bus          (bus),
      .o_busy       (busy),
      .o_done       (done),
      .o_credit_ovf (ovf)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cyc = 0, src_idx = 0;
   int img_beats = 0, pad_beats = 0, data_err = 0, pad_bad = 0, done_cnt = 0;
   int beat_seen = 0, beat_cyc = 0;
   int b0, t0, first;

   function automatic logic [7:0] pix(input int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // One clock: observe at the falling edge, then advance past the rising edge
   task automatic cycle();
      @(negedge clk);
      beat_seen = 0;
      if (done === 1'b1) done_cnt++;
      if (bus.o_data_valid === 1'b1 && bus.i_proc_ready === 1'b1) begin
         if (bus.s_ready === 1'b1) begin
            if (bus.o_data !== pix(src_idx)) data_err++;
            img_beats++;
            src_idx++;
            beat_seen = 1;
            beat_cyc  = cyc;
         end else begin
            pad_beats++;
            if (bus.o_data !== 8'h00) pad_bad++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      bus.s_data = pix(src_idx);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic pulse(input int n);
      bus.i_intr = 1'b1;
      cycle();
      bus.i_intr = 1'b0;
      run(n - 1);
   endtask

   task automatic new_frame();
      src_idx = 0; img_beats = 0; pad_beats = 0;
      data_err = 0; pad_bad = 0; done_cnt = 0;
      bus.s_data = pix(0);
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   initial begin
      bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.i_proc_ready = 1'b0;
      bus.i_intr = 1'b0;  bus.i_out_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_s_ready", bus.s_ready, 0);
      chk("rst_valid", bus.o_data_valid, 0);
      chk("rst_data", bus.o_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run(2);

      // Interrupt in idle must not grant a line; prime sends exactly 32 beats
      pulse(5);
      bus.s_valid = 1'b1; bus.i_proc_ready = 1'b1;
      new_frame();
      run(59);
      chk("prime_beats", img_beats, PRIME_LINES * LINE_LEN);
      chk("prime_data", data_err, 0);
      chk("prime_wait_valid", bus.o_data_valid, 0);
      chk("prime_busy", busy, 1);

      // One line per interrupt edge, first beat three cycles after the edge
      for (int k = 0; k < 4; k++) begin
         b0 = img_beats; first = -1;
         bus.i_intr = 1'b1; t0 = cyc;
         for (int i = 0; i < 20; i++) begin
            cycle();
            bus.i_intr = 1'b0;
            if (beat_seen != 0 && first < 0) first = beat_cyc - t0;
         end
         chk("line_beats", img_beats - b0, LINE_LEN);
         chk("line_latency", first, 3);
      end
      chk("image_total", img_beats, IMG_PIXELS);
      chk("image_data", data_err, 0);

      // Zero lines, then output counting to done
      pulse(20);
      pulse(20);
      chk("pad_beats", pad_beats, EXP_PAD);
      chk("pad_zero", pad_bad, 0);
      chk("pad_busy", busy, 1);
      bus.i_out_valid = 1'b1;
      run(64);
      bus.i_out_valid = 1'b0;
      chk("drain_busy", busy, 1);
      chk("drain_done_low", done, 0);
      run(1);
      chk("done_pulse", done, 1);
      chk("done_busy_low", busy, 0);
      run(5);
      chk("done_count", done_cnt, 1);

      // Random source bubbles and processor backpressure
      bus.s_valid = ($urandom_range(3) != 0);
      bus.i_proc_ready = ($urandom_range(3) != 0);
      new_frame();
      for (int i = 0; i < 400 && img_beats < PRIME_LINES * LINE_LEN; i++) begin
         bus.s_valid = ($urandom_range(3) != 0);
         bus.i_proc_ready = ($urandom_range(3) != 0);
         cycle();
      end
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < 40; i++) begin
            bus.i_intr = (i == 0);
            bus.s_valid = ($urandom_range(3) != 0);
            bus.i_proc_ready = ($urandom_range(3) != 0);
            cycle();
         end
      end
      bus.i_intr = 1'b0; bus.s_valid = 1'b1; bus.i_proc_ready = 1'b1;
      run(10);
      chk("bp_image", img_beats, IMG_PIXELS);
      chk("bp_pad", pad_beats, EXP_PAD);
      chk("bp_data", data_err, 0);
      chk("bp_pad_zero", pad_bad, 0);
      bus.i_out_valid = 1'b1;
      run(70);
      bus.i_out_valid = 1'b0;
      run(5);
      chk("bp_done_count", done_cnt, 1);
      chk("bp_busy", busy, 0);

      // Credit overflow while prime is stalled
      bus.s_valid = 1'b0;
      new_frame();
      run(2);
      for (int k = 0; k < 4; k++) pulse(3);
      chk("ovf_set", ovf, 1);
      bus.s_valid = 1'b1;
      run(100);
      chk("ovf_credit3_lines", img_beats, PRIME_LINES * LINE_LEN + 3 * LINE_LEN);
      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("busy_start_ignored", ovf, 1);
      pulse(20);
      chk("ovf_image", img_beats, IMG_PIXELS);
      pulse(20);
      pulse(20);
      bus.i_out_valid = 1'b1;
      run(64);
      bus.i_out_valid = 1'b0;
      run(5);
      chk("ovf_done", done_cnt, 1);

      // Asynchronous reset in the middle of the first released line
      new_frame();
      chk("ovf_cleared", ovf, 0);
      for (int i = 0; i < 100 && img_beats < PRIME_LINES * LINE_LEN; i++) cycle();
      bus.i_intr = 1'b1;
      cycle();
      bus.i_intr = 1'b0;
      for (int i = 0; i < 30 && img_beats < PRIME_LINES * LINE_LEN + 3; i++) cycle();
      chk("mid_line_beats", img_beats, PRIME_LINES * LINE_LEN + 3);
      chk("mid_line_valid", bus.o_data_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.o_data_valid, 0);
      chk("arst_s_ready", bus.s_ready, 0);
      chk("arst_data", bus.o_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run(1);
      new_frame();
      run(59);
      chk("reprime_beats", img_beats, PRIME_LINES * LINE_LEN);
      chk("reprime_data", data_err, 0);
      chk("reprime_wait_valid", bus.o_data_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
